// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and default run lengths for the multiply/divide sequencing controller.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10,
        EXC  = 2'b11
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEFAULT_MULT_CYCLES = 32;
    localparam int DEFAULT_DIV_CYCLES  = 32;

    localparam int COUNT_W = 6;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences a fixed-length multiply or divide run, then writes HI/LO back or
// raises a divide-by-zero exception; all outputs decode from state and md_sel.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic op_start,
    input  logic op_sel,
    input  logic divisor_zero,
    input  logic abort,
    output logic mult_go,
    output logic div_go,
    output logic md_sel,
    output logic hilo_write,
    output logic busy,
    output logic done,
    output logic div0_exc
);

    localparam logic [COUNT_W-1:0] MULT_LOAD = COUNT_W'(MULT_CYCLES);
    localparam logic [COUNT_W-1:0] DIV_LOAD  = COUNT_W'(DIV_CYCLES);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               md_sel_q;
    logic               md_sel_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            md_sel_q <= OP_MULT;
        end else begin
            state    <= state_next;
            count    <= count_next;
            md_sel_q <= md_sel_next;
        end
    end

    // RUN always holds a count of at least 1, so decrementing there never wraps.
    always_comb begin
        state_next  = state;
        count_next  = count;
        md_sel_next = md_sel_q;
        unique case (state)
            IDLE: begin
                if (op_start && !abort) begin
                    md_sel_next = op_sel;
                    count_next  = (op_sel == OP_DIV) ? DIV_LOAD : MULT_LOAD;
                    state_next  = (op_sel == OP_DIV && divisor_zero) ? EXC : RUN;
                end
            end
            RUN: begin
                count_next = count - COUNT_ONE;
                if (abort) begin
                    state_next = IDLE;
                end else if (count == COUNT_ONE) begin
                    state_next = WB;
                end
            end
            WB:  state_next = IDLE;
            EXC: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign md_sel     = md_sel_q;
    assign mult_go    = (state == RUN) && (md_sel_q == OP_MULT);
    assign div_go     = (state == RUN) && (md_sel_q == OP_DIV);
    assign hilo_write = (state == WB);
    assign done       = (state == WB);
    assign div0_exc   = (state == EXC);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus random traffic
// checked against a transaction-timeline reference model.
module tb_muldiv_ctrl;

    localparam int MULT_N = 32;
    localparam int DIV_N  = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic op_start = 1'b0;
    logic op_sel = 1'b0;
    logic divisor_zero = 1'b0;
    logic abort = 1'b0;
    logic mult_go, div_go, md_sel, hilo_write, busy, done, div0_exc;

    int checks = 0;
    int errors = 0;

    // Observed and expected output vectors:
    // [6] mult_go [5] div_go [4] md_sel [3] hilo_write [2] busy [1] done [0] div0_exc
    logic [6:0] obs;
    logic [6:0] exp_out;

    // Timeline model: a transaction accepted at edge k_edge is active for edges
    // k_edge .. end_edge-1 (outputs observed just after each of those edges).
    int   edge_no  = 0;
    bit   have_txn = 1'b0;
    int   k_edge   = 0;
    int   k_n      = 0;
    bit   k_exc    = 1'b0;
    int   end_edge = 0;
    logic exp_md   = 1'b0;

    muldiv_ctrl #(
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .op_start    (op_start),
        .op_sel      (op_sel),
        .divisor_zero(divisor_zero),
        .abort       (abort),
        .mult_go     (mult_go),
        .div_go      (div_go),
        .md_sel      (md_sel),
        .hilo_write  (hilo_write),
        .busy        (busy),
        .done        (done),
        .div0_exc    (div0_exc)
    );

    always #5 clock = ~clock;

    task automatic model_edge(input logic st, input logic sel, input logic dz,
                              input logic ab, input logic rs);
        bit was_idle;
        edge_no++;
        was_idle = !have_txn || (edge_no - 1 >= end_edge);
        if (rs) begin
            have_txn = 1'b0;
            exp_md   = 1'b0;
        end else if (!was_idle) begin
            if (ab && !k_exc && (edge_no - 1 < k_edge + k_n))
                end_edge = edge_no;
        end else if (st && !ab) begin
            have_txn = 1'b1;
            k_edge   = edge_no;
            exp_md   = sel;
            k_exc    = sel && dz;
            k_n      = sel ? DIV_N : MULT_N;
            end_edge = k_exc ? edge_no + 1 : edge_no + k_n + 1;
        end
        exp_out    = '0;
        exp_out[4] = exp_md;
        if (have_txn && edge_no < end_edge) begin
            exp_out[2] = 1'b1;
            if (k_exc)
                exp_out[0] = 1'b1;
            else if (edge_no < k_edge + k_n)
                exp_out[exp_md ? 5 : 6] = 1'b1;
            else begin
                exp_out[3] = 1'b1;
                exp_out[1] = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sel, input logic dz,
                                 input logic ab, input logic rs);
        @(negedge clock);
        op_start     = st;
        op_sel       = sel;
        divisor_zero = dz;
        abort        = ab;
        reset        = rs;
        @(posedge clock);
        model_edge(st, sel, dz, ab, rs);
        #1;
        obs = {mult_go, div_go, md_sel, hilo_write, busy, done, div0_exc};
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs step %0d: got %b want %b", i, obs, 7'b0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_out) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b want %b", obs, exp_out);
        end
    endtask

    task automatic test_mult_default;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 34; c++) begin
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL mult_model cycle %0d: got %b want %b", c, obs, exp_out);
            end
            if (c <= 32) begin
                checks++;
                if (mult_go !== 1'b1 || div_go !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mult_go cycle %0d: got %b%b want 10", c, mult_go, div_go);
                end
            end
            if (c == 33) begin
                checks++;
                if (hilo_write !== 1'b1 || done !== 1'b1 || mult_go !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mult_wb: got hilo=%b done=%b go=%b want 1 1 0",
                             hilo_write, done, mult_go);
                end
            end
            if (c == 34) begin
                checks++;
                if (md_sel !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mult_idle: got md_sel=%b busy=%b want 0 0", md_sel, busy);
                end
            end
            if (c < 34) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_div;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL div_model cycle %0d: got %b want %b", c, obs, exp_out);
            end
            checks++;
            if (div_go !== (c <= 5) || hilo_write !== (c == 6) || (c <= 6 && md_sel !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL div_timing cycle %0d: got go=%b hilo=%b md_sel=%b",
                         c, div_go, hilo_write, md_sel);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_div_zero;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL div0_model cycle %0d: got %b want %b", c, obs, exp_out);
            end
            checks++;
            if (div0_exc !== (c == 1) || div_go !== 1'b0 || hilo_write !== 1'b0 ||
                done !== 1'b0 || busy !== (c == 1)) begin
                errors++;
                $display("[TB] FAIL div0_outputs cycle %0d: got exc=%b go=%b hilo=%b done=%b busy=%b",
                         c, div0_exc, div_go, hilo_write, done, busy);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort;
        bit saw_wb;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            checks++;
            if (obs !== exp_out || hilo_write !== 1'b0 || done !== 1'b0 ||
                (c >= 11 && busy !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL abort cycle %0d: got %b want %b", c, obs, exp_out);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, c == 10, 1'b0);
        end
        saw_wb = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 34; c++) begin
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL after_abort cycle %0d: got %b want %b", c, obs, exp_out);
            end
            if (c == 33 && hilo_write === 1'b1) saw_wb = 1'b1;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (saw_wb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_abort_wb: got %b want 1", saw_wb);
        end
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            checks++;
            if (obs !== exp_out || (c == 33 && (hilo_write !== 1'b1 || done !== 1'b1)) ||
                (c >= 34 && busy !== 1'b0) || md_sel !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_start cycle %0d: got %b want %b", c, obs, exp_out);
            end
            applyStimulus(c == 3 || c == 33 || c == 34, 1'b1, 1'b0, 1'b0, 1'b0);
            if (c == 34) c = 36;
        end
        // the start sampled on the IDLE edge after WB is accepted normally
        checks++;
        if (obs !== exp_out || div_go !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_after_wb: got %b want %b", obs, exp_out);
        end
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (obs !== exp_out || (c >= 8 && (obs !== 7'b0))) begin
                errors++;
                $display("[TB] FAIL reset_mid cycle %0d: got %b want %b", c, obs, exp_out);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, c == 7);
        end
    endtask

    task automatic test_priority;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (obs !== exp_out || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL priority cycle %0d: got %b want %b", c, obs, exp_out);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random;
        logic st, sel, dz, ab, rs;
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(99, 0) < 35);
            sel = $urandom_range(1, 0);
            dz  = ($urandom_range(99, 0) < 25);
            ab  = ($urandom_range(99, 0) < 4);
            rs  = ($urandom_range(199, 0) < 2);
            applyStimulus(st, sel, dz, ab, rs);
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL random step %0d: got %b want %b", i, obs, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_default();
        test_div();
        test_div_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
